// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: excitation codes, default width and the
// (current, next) -> {J,K} excitation function used by JK-based counters.
package jk_pkg;

  // JK input codes, packed as {J, K}.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int JK_DEFAULT_WIDTH = 4;

  // Excitation table: set only on 0->1, reset only on 1->0, hold otherwise.
  // JK_TOGGLE is never produced, so J and K are never both high.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return {~cur & nxt, cur & ~nxt};
  endfunction

endpackage

// File: rtl/jkff.sv
// Single JK flip-flop with synchronous active-high reset.
module jkff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update; reset wins over any J/K code.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excitation_counter.sv
// Up/down modulo counter (range 0..max_val) built from JK flip-flops.
// The next count is computed in binary, then translated per bit into J/K
// drive through the excitation table; tc is a registered wrap pulse.
module jk_excitation_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = JK_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] n;
  logic             wrap;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // Next count, wrap flag and per-bit J/K excitation; priority rst > load > en > hold.
  // Reset is folded in so J/K always describe the transition the flops take.
  always_comb begin
    n     = q;
    wrap  = 1'b0;
    j_vec = '0;
    k_vec = '0;
    if (rst) begin
      n = '0;
    end else if (load) begin
      n = (din <= max_val) ? din : '0;
    end else if (en) begin
      if (up) begin
        if (q >= max_val) begin
          n    = '0;
          wrap = 1'b1;
        end else begin
          n = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          n    = max_val;
          wrap = 1'b1;
        end else if (q > max_val) begin
          n = max_val;
        end else begin
          n = q - WIDTH'(1);
        end
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      logic [1:0] code;
      code     = jk_excite(q[i], n[i]);
      j_vec[i] = code[1];
      k_vec[i] = code[0];
    end
  end

  // One JK flop per count bit; q comes straight from flop state.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff u_jkff (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i])
    );
  end

  // Registered wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b0;
    end else begin
      tc <= wrap;
    end
  end

endmodule

// File: tb/tb_jk_excitation_counter.sv
module tb_jk_excitation_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] max_val = '0;
  logic [W-1:0] q;
  logic         tc;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q_q[$];
  logic         exp_tc_q[$];
  string        name_q[$];

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_j;
  logic [W-1:0] pre_k;
  logic         have_pre = 1'b0;

  jk_excitation_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .din     (din),
    .max_val (max_val),
    .q       (q),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  // Capture pre-edge flop state and J/K drive once inputs have settled.
  always @(negedge clk) begin
    #3;
    pre_q    = q;
    pre_j    = dut.j_vec;
    pre_k    = dut.k_vec;
    have_pre = !$isunknown(pre_q);
  end

  // Monitor: after each edge check J/K against the observed transition and
  // pop the scoreboard entry for this edge.
  always @(posedge clk) begin
    logic [W-1:0] eq;
    logic         et;
    string        nm;
    #1;
    if (have_pre) begin
      for (int i = 0; i < W; i++) begin
        total++;
        if ((pre_j[i] & pre_k[i]) ||
            (pre_j[i] !== (~pre_q[i] & q[i])) ||
            (pre_k[i] !== (pre_q[i] & ~q[i]))) begin
          bad++;
          $display("FAIL jk_bit%0d: j=%0b k=%0b for q %0b->%0b, expected j=%0b k=%0b",
                   i, pre_j[i], pre_k[i], pre_q[i], q[i],
                   ~pre_q[i] & q[i], pre_q[i] & ~q[i]);
        end
      end
    end
    if (exp_q_q.size() > 0) begin
      eq = exp_q_q.pop_front();
      et = exp_tc_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (q !== eq || tc !== et) begin
        bad++;
        $display("FAIL %s: got q=%0d tc=%0b, expected q=%0d tc=%0b", nm, q, tc, eq, et);
      end
    end
  end

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [W-1:0] d, input logic [W-1:0] m,
                      input logic [W-1:0] eq, input logic et, input string nm);
    @(negedge clk);
    rst     = r;
    load    = l;
    en      = e;
    up      = u;
    din     = d;
    max_val = m;
    exp_q_q.push_back(eq);
    exp_tc_q.push_back(et);
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    // reset beats load and en
    step(1, 1, 1, 1, 4'd7, 4'd9, 4'd0, 1'b0, "reset_over_load");
    step(0, 0, 1, 1, 4'd0, 4'd9, 4'd1, 1'b0, "resume_after_reset");
    // up count 0..9 then wrap
    step(0, 1, 0, 1, 4'd0, 4'd9, 4'd0, 1'b0, "load_zero");
    for (int i = 1; i <= 9; i++)
      step(0, 0, 1, 1, 4'd0, 4'd9, W'(i), 1'b0, "up_count");
    step(0, 0, 1, 1, 4'd0, 4'd9, 4'd0, 1'b1, "up_wrap");
    step(0, 0, 0, 1, 4'd0, 4'd9, 4'd0, 1'b0, "hold_clears_tc");
    // down wrap from zero
    step(0, 0, 1, 0, 4'd0, 4'd5, 4'd5, 1'b1, "down_wrap");
    step(0, 0, 1, 0, 4'd0, 4'd5, 4'd4, 1'b0, "down_step");
    // clamp when above a lowered terminal count
    step(0, 1, 0, 0, 4'd12, 4'd15, 4'd12, 1'b0, "load_12");
    step(0, 0, 1, 0, 4'd0, 4'd5, 4'd5, 1'b0, "down_clamp");
    // load beats enable; out-of-range load gives zero
    step(0, 1, 1, 1, 4'd3, 4'd9, 4'd3, 1'b0, "load_priority");
    step(0, 1, 1, 1, 4'd12, 4'd9, 4'd0, 1'b0, "load_over_max");
    // degenerate range
    step(0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1'b1, "max0_up");
    step(0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1'b1, "max0_up");
    step(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1'b1, "max0_down");
    step(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1'b1, "max0_down");
    // terminal count lowered mid-count
    step(0, 1, 0, 1, 4'd7, 4'd9, 4'd7, 1'b0, "load_7");
    step(0, 0, 1, 1, 4'd0, 4'd4, 4'd0, 1'b1, "max_lowered_wrap");
    // reset in the middle of counting
    step(0, 0, 1, 1, 4'd0, 4'd9, 4'd1, 1'b0, "count_1");
    step(0, 0, 1, 1, 4'd0, 4'd9, 4'd2, 1'b0, "count_2");
    step(1, 1, 1, 1, 4'd5, 4'd9, 4'd0, 1'b0, "reset_mid_count");
    step(0, 0, 0, 1, 4'd0, 4'd9, 4'd0, 1'b0, "idle_after_reset");
    // reset right after a wrap leaves no residual tc
    step(0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1'b1, "wrap_before_reset");
    step(1, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1'b0, "reset_kills_tc");
    step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1'b0, "no_residual_tc");
    step(0, 0, 1, 0, 4'd0, 4'd9, 4'd9, 1'b1, "resume_down_wrap");
    // clamp from a nonzero value above max, then normal decrement
    step(0, 0, 1, 0, 4'd0, 4'd3, 4'd3, 1'b0, "down_clamp_9_to_3");
    step(0, 0, 1, 0, 4'd0, 4'd3, 4'd2, 1'b0, "down_3_to_2");
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    budget = 10;
    while (exp_q_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
